// File: rtl/dsp_ctrl_align.sv
// Control-alignment delay lines feeding the DSP48 slice and the result BRAM.
// Each control group gets its own depth so it meets the datapath stage that consumes it.
module dsp_ctrl_align #(
  parameter int ADDR_WIDTH    = 5,
  parameter int ALUMODE_WIDTH = 4,
  parameter int OPMODE_WIDTH  = 7,
  parameter int INMODE_WIDTH  = 5,
  parameter int WE_DEPTH      = 3,
  parameter int MODE_DEPTH    = 2,
  parameter int IN_DEPTH      = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic                     bram_we_i,
  input  logic [ADDR_WIDTH-1:0]    bram_w_addr_i,
  input  logic [ALUMODE_WIDTH-1:0] alumode_i,
  input  logic [OPMODE_WIDTH-1:0]  opmode_i,
  input  logic [INMODE_WIDTH-1:0]  inmode_i,
  output logic                     valid_o,
  output logic                     bram_we_o,
  output logic [ADDR_WIDTH-1:0]    bram_w_addr_o,
  output logic [ALUMODE_WIDTH-1:0] alumode_o,
  output logic [OPMODE_WIDTH-1:0]  opmode_o,
  output logic [INMODE_WIDTH-1:0]  inmode_o,
  output logic                     busy_o,
  output logic [CNT_WIDTH-1:0]     wr_cnt_o
);

  if (WE_DEPTH < 1 || WE_DEPTH > 8 || MODE_DEPTH < 1 || MODE_DEPTH > WE_DEPTH ||
      IN_DEPTH < 1 || IN_DEPTH > WE_DEPTH || CNT_WIDTH < 1) begin : g_param_err
    $error("dsp_ctrl_align: illegal depth parameters");
  end

  logic [WE_DEPTH-1:0]      valid_reg, valid_next;
  logic [WE_DEPTH-1:0]      we_reg, we_next;
  logic [ADDR_WIDTH-1:0]    addr_reg    [WE_DEPTH];
  logic [ADDR_WIDTH-1:0]    addr_next   [WE_DEPTH];
  logic [ALUMODE_WIDTH-1:0] alumode_reg [MODE_DEPTH];
  logic [ALUMODE_WIDTH-1:0] alumode_next[MODE_DEPTH];
  logic [OPMODE_WIDTH-1:0]  opmode_reg  [MODE_DEPTH];
  logic [OPMODE_WIDTH-1:0]  opmode_next [MODE_DEPTH];
  logic [INMODE_WIDTH-1:0]  inmode_reg  [IN_DEPTH];
  logic [INMODE_WIDTH-1:0]  inmode_next [IN_DEPTH];
  logic [CNT_WIDTH-1:0]     wr_cnt_reg;

  // A strobe without valid never enters the chain.
  for (genvar gi = 0; gi < WE_DEPTH; gi++) begin : g_we_stage
    if (gi == 0) begin : g_head
      assign valid_next[gi] = valid_i;
      assign we_next[gi]    = bram_we_i & valid_i;
      assign addr_next[gi]  = bram_w_addr_i;
    end else begin : g_body
      assign valid_next[gi] = valid_reg[gi-1];
      assign we_next[gi]    = we_reg[gi-1];
      assign addr_next[gi]  = addr_reg[gi-1];
    end
  end

  for (genvar gi = 0; gi < MODE_DEPTH; gi++) begin : g_mode_stage
    if (gi == 0) begin : g_head
      assign alumode_next[gi] = alumode_i;
      assign opmode_next[gi]  = opmode_i;
    end else begin : g_body
      assign alumode_next[gi] = alumode_reg[gi-1];
      assign opmode_next[gi]  = opmode_reg[gi-1];
    end
  end

  for (genvar gi = 0; gi < IN_DEPTH; gi++) begin : g_in_stage
    if (gi == 0) begin : g_head
      assign inmode_next[gi] = inmode_i;
    end else begin : g_body
      assign inmode_next[gi] = inmode_reg[gi-1];
    end
  end

  // Flush kills only the valid/strobe bits; payload stages keep their values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg  <= '0;
      we_reg     <= '0;
      wr_cnt_reg <= '0;
    end else if (flush_i) begin
      valid_reg  <= '0;
      we_reg     <= '0;
    end else if (en_i) begin
      valid_reg <= valid_next;
      we_reg    <= we_next;
      if (we_next[WE_DEPTH-1]) begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_reg    <= '{default: '0};
      alumode_reg <= '{default: '0};
      opmode_reg  <= '{default: '0};
      inmode_reg  <= '{default: '0};
    end else if (en_i && !flush_i) begin
      addr_reg    <= addr_next;
      alumode_reg <= alumode_next;
      opmode_reg  <= opmode_next;
      inmode_reg  <= inmode_next;
    end
  end

  assign valid_o       = valid_reg[WE_DEPTH-1];
  assign bram_we_o     = we_reg[WE_DEPTH-1];
  assign bram_w_addr_o = addr_reg[WE_DEPTH-1];
  assign alumode_o     = alumode_reg[MODE_DEPTH-1];
  assign opmode_o      = opmode_reg[MODE_DEPTH-1];
  assign inmode_o      = inmode_reg[IN_DEPTH-1];
  assign busy_o        = |valid_reg;
  assign wr_cnt_o      = wr_cnt_reg;

endmodule

// File: tb/tb_dsp_ctrl_align.sv
// Scoreboarded bench for dsp_ctrl_align: directed stream, stall, flush, gating,
// counter wrap (second instance with a 2-bit counter) and asynchronous reset.
module tb_dsp_ctrl_align;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       en_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       bram_we_i = 1'b0;
  logic [4:0] bram_w_addr_i = '0;
  logic [3:0] alumode_i = '0;
  logic [6:0] opmode_i = '0;
  logic [4:0] inmode_i = '0;

  logic        valid_o, bram_we_o, busy_o;
  logic [4:0]  bram_w_addr_o, inmode_o;
  logic [3:0]  alumode_o;
  logic [6:0]  opmode_o;
  logic [15:0] wr_cnt_o;

  logic        w_valid_o, w_bram_we_o, w_busy_o;
  logic [4:0]  w_bram_w_addr_o, w_inmode_o;
  logic [3:0]  w_alumode_o;
  logic [6:0]  w_opmode_o;
  logic [1:0]  w_wr_cnt_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0] addr;
    logic       we;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  dsp_ctrl_align u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i),
    .valid_i(valid_i), .bram_we_i(bram_we_i), .bram_w_addr_i(bram_w_addr_i),
    .alumode_i(alumode_i), .opmode_i(opmode_i), .inmode_i(inmode_i),
    .valid_o(valid_o), .bram_we_o(bram_we_o), .bram_w_addr_o(bram_w_addr_o),
    .alumode_o(alumode_o), .opmode_o(opmode_o), .inmode_o(inmode_o),
    .busy_o(busy_o), .wr_cnt_o(wr_cnt_o)
  );

  dsp_ctrl_align #(.CNT_WIDTH(2)) u_wrap (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i),
    .valid_i(valid_i), .bram_we_i(bram_we_i), .bram_w_addr_i(bram_w_addr_i),
    .alumode_i(alumode_i), .opmode_i(opmode_i), .inmode_i(inmode_i),
    .valid_o(w_valid_o), .bram_we_o(w_bram_we_o), .bram_w_addr_o(w_bram_w_addr_o),
    .alumode_o(w_alumode_o), .opmode_o(w_opmode_o), .inmode_o(w_inmode_o),
    .busy_o(w_busy_o), .wr_cnt_o(w_wr_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one word; words that must reach the output are queued for the monitor.
  task automatic drive(input logic v, input logic we, input logic [4:0] addr,
                       input logic [6:0] mode, input bit push);
    valid_i       = v;
    bram_we_i     = we;
    bram_w_addr_i = addr;
    alumode_i     = mode[3:0];
    opmode_i      = mode;
    inmode_i      = mode[4:0];
    if (push) begin
      exp_t e;
      e.addr = addr;
      e.we   = we & v;
      sb_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: a word is presented once, on the first negedge after an advancing edge.
  logic adv;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) adv <= 1'b0;
    else         adv <= en_i && !flush_i;
  end

  always @(negedge clk_i) begin
    if (rst_ni && adv && valid_o) begin
      if (sb_q.size() == 0) begin
        check("mon_unexpected_word", 32'(bram_w_addr_o), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("mon_addr", 32'(bram_w_addr_o), 32'(e.addr));
        check("mon_we", 32'(bram_we_o), 32'(e.we));
        $display("word addr=%0d we=%0d cnt=%0d", bram_w_addr_o, bram_we_o, wr_cnt_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(valid_o), 0);
    check("rst_we", 32'(bram_we_o), 0);
    check("rst_addr", 32'(bram_w_addr_o), 0);
    check("rst_alumode", 32'(alumode_o), 0);
    check("rst_opmode", 32'(opmode_o), 0);
    check("rst_inmode", 32'(inmode_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_cnt", 32'(wr_cnt_o), 0);
    rst_ni = 1'b1;
    en_i = 1'b1;

    // Full-rate stream of 8 writes
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 5'(k), 7'(k), 1'b1);
      tick();
      check("stream_inmode", 32'(inmode_o), 32'(k));
      check("stream_alumode", 32'(alumode_o), (k >= 1) ? 32'(k - 1) : 0);
      check("stream_opmode", 32'(opmode_o), (k >= 1) ? 32'(k - 1) : 0);
      check("stream_cnt", 32'(wr_cnt_o), (k >= 2) ? 32'(k - 1) : 0);
      check("stream_wrap_cnt", 32'(w_wr_cnt_o), (k >= 2) ? 32'((k - 1) % 4) : 0);
    end
    drive(1'b0, 1'b0, 5'd0, 7'd0, 1'b0);
    for (int t = 1; t <= 2; t++) begin
      tick();
      check("drain_cnt", 32'(wr_cnt_o), 32'(6 + t));
      check("drain_wrap_cnt", 32'(w_wr_cnt_o), 32'((6 + t) % 4));
      if (t == 1) check("drain_alumode", 32'(alumode_o), 7);
    end
    tick();
    check("drain_busy", 32'(busy_o), 0);
    check("drain_valid", 32'(valid_o), 0);

    // Stall: one word then 4 held edges
    drive(1'b1, 1'b1, 5'd5, 7'd9, 1'b1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 7'd0, 1'b0);
    en_i = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      check("stall_valid", 32'(valid_o), 0);
      check("stall_inmode", 32'(inmode_o), 9);
      check("stall_busy", 32'(busy_o), 1);
      check("stall_cnt", 32'(wr_cnt_o), 8);
    end
    en_i = 1'b1;
    tick();
    check("stall_valid_early", 32'(valid_o), 0);
    check("stall_alumode", 32'(alumode_o), 9);
    tick();
    check("stall_out_we", 32'(bram_we_o), 1);
    check("stall_out_addr", 32'(bram_w_addr_o), 5);
    check("stall_out_cnt", 32'(wr_cnt_o), 9);
    tick();
    check("stall_after_cnt", 32'(wr_cnt_o), 9);

    // Flush with writes in flight and a new word on the flush edge
    drive(1'b1, 1'b1, 5'd1, 7'd1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd2, 7'd2, 1'b0);
    tick();
    check("preflush_busy", 32'(busy_o), 1);
    drive(1'b1, 1'b1, 5'd4, 7'd4, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_busy", 32'(busy_o), 0);
    check("flush_we", 32'(bram_we_o), 0);
    drive(1'b0, 1'b0, 5'd0, 7'd0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      tick();
      check("postflush_we", 32'(bram_we_o), 0);
      check("postflush_busy", 32'(busy_o), 0);
      check("postflush_cnt", 32'(wr_cnt_o), 9);
    end

    // Strobe without valid is dropped
    for (int g = 0; g < 5; g++) begin
      drive(1'b0, 1'b1, 5'(g + 10), 7'd3, 1'b0);
      tick();
      check("gate_we", 32'(bram_we_o), 0);
      check("gate_valid", 32'(valid_o), 0);
      check("gate_busy", 32'(busy_o), 0);
    end
    check("gate_cnt", 32'(wr_cnt_o), 9);

    // Asynchronous reset while busy
    drive(1'b1, 1'b1, 5'd6, 7'd6, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 7'd0, 1'b0);
    check("prereset_busy", 32'(busy_o), 1);
    #2;
    rst_ni = 1'b0;
    sb_q.delete();
    #1;
    check("arst_valid", 32'(valid_o), 0);
    check("arst_we", 32'(bram_we_o), 0);
    check("arst_inmode", 32'(inmode_o), 0);
    check("arst_busy", 32'(busy_o), 0);
    check("arst_cnt", 32'(wr_cnt_o), 0);
    check("arst_wrap_cnt", 32'(w_wr_cnt_o), 0);
    tick();
    rst_ni = 1'b1;

    // First word after reset takes the full latency
    drive(1'b1, 1'b1, 5'd3, 7'd2, 1'b1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 7'd0, 1'b0);
    check("relat_e1_valid", 32'(valid_o), 0);
    tick();
    check("relat_e2_valid", 32'(valid_o), 0);
    tick();
    check("relat_e3_valid", 32'(valid_o), 1);
    check("relat_e3_addr", 32'(bram_w_addr_o), 3);
    check("relat_e3_cnt", 32'(wr_cnt_o), 1);
    tick();
    tick();
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
